demux_chan_deser: RTL

//  Downstream stage of the 1:4 bit demultiplexer. Takes the serial bit (i) and its
//  2-bit channel select (sel) and assembles a WIDTH-bit word per channel in 4

---
 rtl/demux_chan_deser.sv | 112 +++++++++++
 1 files changed

// File: rtl/demux_chan_deser.sv
// Four-channel serial-to-parallel deserializer with per-channel output handshake.
// Optional partial-word flush port enabled by defining DEMUX_FLUSH_EN.
module demux_chan_deser #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef DEMUX_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           sel,
  input  logic                 i,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready
);

  localparam int unsigned NCH  = 4;
  localparam int unsigned CW   = $clog2(WIDTH);
  localparam int unsigned LAST = WIDTH - 1;

  logic [CW-1:0]    cnt_q   [NCH];
  logic [CW-1:0]    cnt_d   [NCH];
  logic [WIDTH-1:0] shift_q [NCH];
  logic [WIDTH-1:0] shift_d [NCH];
  logic [WIDTH-1:0] hold_q  [NCH];
  logic [WIDTH-1:0] hold_d  [NCH];
  logic [NCH-1:0]   vld_q;
  logic [NCH-1:0]   vld_d;

  logic             flush_c;
  logic             accept_c;
  logic             last_c;
  logic [WIDTH-1:0] shifted_c;

`ifdef DEMUX_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // The completing bit stalls only when the hold register cannot drain this cycle.
  always_comb begin
    last_c   = (cnt_q[sel] == CW'(LAST));
    in_ready = !(last_c && vld_q[sel] && !out_ready[sel]) && !flush_c;
    accept_c = in_valid && in_ready;
  end

  always_comb begin
    if (MSB_FIRST) begin
      shifted_c = {shift_q[sel][WIDTH-2:0], i};
    end else begin
      shifted_c = {i, shift_q[sel][WIDTH-1:1]};
    end
  end

  // Next state: pops first, then flush, then the accepted bit for channel sel.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      cnt_d[k]   = cnt_q[k];
      shift_d[k] = shift_q[k];
      hold_d[k]  = hold_q[k];
    end
    vld_d = vld_q & ~out_ready;

    if (flush_c) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_d[k]   = '0;
        shift_d[k] = '0;
      end
    end

    if (accept_c) begin
      shift_d[sel] = shifted_c;
      if (last_c) begin
        hold_d[sel] = shifted_c;
        vld_d[sel]  = 1'b1;
        cnt_d[sel]  = '0;
      end else begin
        cnt_d[sel]  = cnt_q[sel] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k]   <= '0;
        shift_q[k] <= '0;
        hold_q[k]  <= '0;
      end
      vld_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k]   <= cnt_d[k];
        shift_q[k] <= shift_d[k];
        hold_q[k]  <= hold_d[k];
      end
      vld_q <= vld_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_out
    assign out_data[k*WIDTH +: WIDTH] = hold_q[k];
  end

  assign out_valid = vld_q;

endmodule
